// File: rtl/dds_seq_ctrl.sv
// dds_seq_ctrl: button-driven DDS wave/frequency sequencer that applies staged changes on phase wrap
module dds_debounce #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_level,
  output logic o_edge
);
  localparam int W = $clog2(N + 1);
  localparam logic [W-1:0] LAST = W'(N - 1);
  logic r_s1, r_s2, r_db, r_arm;
  logic [W-1:0] r_cnt;
  logic w_diff, w_hit;
  // until a stable release is seen the counter qualifies arming, so a held button never fires
  assign w_diff = r_arm ? (r_s2 != r_db) : !r_s2;
  assign w_hit = w_diff && (r_cnt == LAST);
  assign o_level = r_db;
  assign o_edge = r_arm && w_hit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_db <= 1'b0;
      r_arm <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= !i_btn_n;
      r_s2 <= r_s1;
      r_cnt <= (w_diff && !w_hit) ? r_cnt + 1'b1 : '0;
      r_arm <= r_arm || w_hit;
      r_db <= (r_arm && w_hit) ? r_s2 : r_db;
    end
endmodule

module dds_seq_ctrl #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int HOLD_CYCLES = 12000000,
  parameter int DWELL_CYCLES = 6000000,
  parameter int WRAP_TIMEOUT = 24000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        boot_n,
  input  logic        sw_n,
  input  logic        phase_wrap,
  output logic [1:0]  wave_sel,
  output logic [1:0]  freq_sel,
  output logic [31:0] phase_inc,
  output logic        cfg_update,
  output logic        pending,
  output logic        sweep_active
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam int TW = $clog2(WRAP_TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(WRAP_TIMEOUT);
  typedef enum logic {S_IDLE, S_PENDING} state_t;
  state_t r_state, w_next;
  logic w_boot_lvl, w_boot_edge, w_sw_lvl, w_sw_edge;
  logic w_boot_rise, w_long_hit, w_short, w_step, w_freq_ev, w_ev, w_apply;
  logic [HW-1:0] r_hold;
  logic [DW-1:0] r_dwell;
  logic [TW-1:0] r_to;
  logic r_long;
  logic [1:0] r_stg_wave, r_stg_freq, w_wave_n, w_freq_n;

  function automatic logic [31:0] inc_lut(input logic [1:0] f);
    return f == 2'd0 ? 32'd357913 : f == 2'd1 ? 32'd715827 : f == 2'd2 ? 32'd1789574 : 32'd3578139;
  endfunction

  dds_debounce #(.N(DEBOUNCE_CYCLES)) u_boot (.clk(clk), .rst_n(rst_n), .i_btn_n(boot_n), .o_level(w_boot_lvl), .o_edge(w_boot_edge));
  dds_debounce #(.N(DEBOUNCE_CYCLES)) u_sw (.clk(clk), .rst_n(rst_n), .i_btn_n(sw_n), .o_level(w_sw_lvl), .o_edge(w_sw_edge));

  assign w_boot_rise = w_boot_edge && !w_boot_lvl;
  assign w_long_hit = w_sw_lvl && !r_long && (r_hold == HOLD_LAST);
  assign w_short = w_sw_edge && w_sw_lvl && !r_long && !w_long_hit;
  assign w_step = sweep_active && (r_dwell == DWELL_LAST);
  assign w_freq_ev = w_short || w_step;
  assign w_ev = w_boot_rise || w_freq_ev;
  assign w_wave_n = w_boot_rise ? (r_stg_wave == 2'd2 ? 2'd0 : r_stg_wave + 2'd1) : r_stg_wave;
  assign w_freq_n = r_stg_freq + {1'b0, w_freq_ev};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb
    w_next = (r_state == S_IDLE) ? (w_ev ? S_PENDING : S_IDLE) : (w_apply ? S_IDLE : S_PENDING);

  always_comb begin
    pending = (r_state == S_PENDING);
    w_apply = pending && (phase_wrap || r_to == TO_MAX);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_hold <= '0;
      r_long <= 1'b0;
      sweep_active <= 1'b0;
      r_dwell <= '0;
      r_to <= '0;
      r_stg_wave <= 2'd0;
      r_stg_freq <= 2'd0;
      wave_sel <= 2'd0;
      freq_sel <= 2'd0;
      phase_inc <= 32'd357913;
      cfg_update <= 1'b0;
    end else begin
      r_hold <= (w_sw_lvl && !r_long && !w_long_hit) ? r_hold + 1'b1 : '0;
      r_long <= w_sw_lvl && (r_long || w_long_hit);
      sweep_active <= sweep_active ^ w_long_hit;
      r_dwell <= (!sweep_active || w_freq_ev) ? '0 : r_dwell + 1'b1;
      r_to <= (pending && !w_apply) ? r_to + 1'b1 : (!pending && w_ev) ? TW'(1) : '0;
      r_stg_wave <= w_wave_n;
      r_stg_freq <= w_freq_n;
      wave_sel <= w_apply ? w_wave_n : wave_sel;
      freq_sel <= w_apply ? w_freq_n : freq_sel;
      phase_inc <= w_apply ? inc_lut(w_freq_n) : phase_inc;
      cfg_update <= w_apply && ({w_wave_n, w_freq_n} != {wave_sel, freq_sel});
    end
endmodule

// File: doc/dds_seq_ctrl.md
DDS_SEQ_CTRL -- requirements
Module: dds_seq_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 120000, consecutive stable synchronized cycles needed to accept a button level (10 ms at 12 MHz).
REQ-002 SHALL have parameter HOLD_CYCLES, default 12000000, sw hold length that counts as a long press (1 s).
REQ-003 SHALL have parameter DWELL_CYCLES, default 6000000, cycles per frequency step in sweep mode (0.5 s).
REQ-004 SHALL have parameter WRAP_TIMEOUT, default 24000, maximum cycles a staged change waits for phase_wrap.
REQ-005 SHALL have ports: clk  in  1  12 MHz clock, single domain.
REQ-006 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: boot_n  in  1  BOOT button, active low, asynchronous to clk.
REQ-008 SHALL have ports: sw_n  in  1  SW button, active low, asynchronous to clk.
REQ-009 SHALL have ports: phase_wrap  in  1  single-cycle pulse from the datapath when the phase accumulator MSB falls (cycle boundary).
REQ-010 SHALL have ports: wave_sel  out  2  applied waveform (0 sine, 1 triangle, 2 square).
REQ-011 SHALL have ports: freq_sel  out  2  applied frequency index (0..3).
REQ-012 SHALL have ports: phase_inc  out  32  applied phase increment.
REQ-013 SHALL have ports: cfg_update  out  1  one-cycle pulse on each applied change.
REQ-014 SHALL have ports: pending  out  1  staged change awaiting application.
REQ-015 SHALL have ports: sweep_active  out  1  auto-sweep mode enabled.

Function
REQ-016 SHALL pass each button through a 2-flop synchronizer with inversion (pressed = 1), then a debouncer: debounced level changes only after DEBOUNCE_CYCLES consecutive cycles of the new synchronized level; any mismatch restarts the count.
REQ-017 SHALL treat a debounced boot rising edge as a wave event: staged wave = 0->1->2->0.
REQ-018 SHALL time sw from the debounced rising edge: a release before HOLD_CYCLES is a short press (freq event on release, staged freq = 0->1->2->3->0); reaching HOLD_CYCLES while held toggles sweep_active in that cycle, after which the release produces no event.
REQ-019 SHALL, with sweep_active=1, run a dwell counter and issue a freq event every DWELL_CYCLES; the counter clears on sweep enable and on any manual freq event.
REQ-020 SHALL merge a manual freq event and a sweep step in the same cycle into a single increment.
REQ-021 SHALL map the staged freq to phase_inc as 0:357913, 1:715827, 2:1789574, 3:3578139; phase_inc is registered, never combinationally derived from the staged value.
REQ-022 SHALL implement an apply FSM with states IDLE and PENDING; an event in IDLE stages the value, starts the timeout counter and enters PENDING; pending = (state == PENDING).
REQ-023 SHALL, in PENDING, update the staged value on further events (latest wins), without restarting the timeout.
REQ-024 SHALL, in PENDING, apply on the edge that samples phase_wrap=1 or the timeout count reaching WRAP_TIMEOUT; wave_sel, freq_sel and phase_inc load together, cfg_update=1 the next cycle, and the state returns to IDLE.
REQ-025 SHALL include events occurring in the apply cycle in the applied value; phase_wrap in IDLE is ignored.
REQ-026 SHALL, when the staged value equals the applied value at apply time, still return to IDLE but not pulse cfg_update.
REQ-027 SHALL handle simultaneous wave and freq events as one staged change applied atomically.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force: wave_sel=0, freq_sel=0, phase_inc=357913, cfg_update=0, pending=0, sweep_active=0, FSM=IDLE, all counters 0, debounced levels 0, synchronizers 0.
REQ-029 SHALL discard a staged change on reset mid-PENDING, and a button held across reset deassertion produces no event until released and re-pressed.

Verification
REQ-030 SHALL cover (DEBOUNCE_CYCLES=4): boot pressed 3 cycles with bounce -> no event; held 10 cycles, then phase_wrap -> wave_sel=1, phase_inc unchanged, one cfg_update pulse.
REQ-031 SHALL cover: sw short press, no phase_wrap (WRAP_TIMEOUT=16) -> pending=1 for 16 cycles, then freq_sel=1, phase_inc=715827.
REQ-032 SHALL cover: four sw short presses before phase_wrap -> single apply, freq_sel=0, cfg_update not pulsed.
REQ-033 SHALL cover (HOLD_CYCLES=20, DWELL_CYCLES=8, phase_wrap every 3 cycles): long sw hold -> sweep_active=1; freq_sel steps 1,2,3,0 at 8-cycle spacing, wrapping 3->0.
REQ-034 SHALL cover: boot event in the same cycle as phase_wrap while PENDING a freq change -> both applied in one cfg_update.
REQ-035 SHALL cover: rst_n pulsed low mid-PENDING with sweep_active=1 -> all outputs at reset values immediately, no cfg_update after release.
